data_mem_responder: RTL and testbench

- Memory-side responder for the MemRead/MemWrite/MemToReg datapath driven by the CPU control unit.
- Accepts one load or store request at a time and holds it for a fixed, parameterised latency.
- Commits the store, or returns load data, with a single-cycle ready pulse.
- Sits between the ALU result/register-file read port and the writeback mux; replaces the ideal zero-latency data RAM.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/dmem_array.sv | 25 ++
 rtl/data_mem_responder.sv | 134 +++++++++++++
 tb/tb_data_mem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: responder FSM states, latency bounds and the datapath width.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DATA_W_DEFAULT = 32;
    localparam int LATENCY_MIN    = 1;
    localparam int LATENCY_MAX    = 15;
    localparam int CNT_W          = 4;

    // A request gets no memory access if it is misaligned or asks for both a load and a store.
    function automatic logic req_is_bad(input logic rd, input logic wr, input logic [1:0] lsb);
        return (rd && wr) || (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage with a synchronous write and a registered read; contents are never reset.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wd;
        end
        if (re) begin
            rd <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: accepts one load/store, counts down LATENCY cycles,
// then commits the store or returns load data with a one-cycle ready pulse.
module data_mem_responder
    import cpu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  idx_q;
    logic [DATA_W-1:0]  wd_q;
    logic               rd_q, wr_q, bad_q;
    logic               loaded_q;

    logic               req;
    logic               accept;
    logic               enter_resp;
    logic [ADDR_W-1:0]  op_idx;
    logic [DATA_W-1:0]  op_wd;
    logic               op_rd, op_wr, op_bad;
    logic               mem_we, mem_re;
    logic [DATA_W-1:0]  mem_rd;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    assign req    = MemRead | MemWrite;
    assign accept = (state_q == IDLE) && req;

    // With LATENCY=1 the access happens on the acceptance edge itself, so use the live inputs in IDLE.
    assign op_idx = (state_q == IDLE) ? addr[ADDR_W+1:2] : idx_q;
    assign op_wd  = (state_q == IDLE) ? wdata : wd_q;
    assign op_rd  = (state_q == IDLE) ? MemRead : rd_q;
    assign op_wr  = (state_q == IDLE) ? MemWrite : wr_q;
    assign op_bad = (state_q == IDLE) ? req_is_bad(MemRead, MemWrite, addr[1:0]) : bad_q;

    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign mem_we     = enter_resp && op_wr && !op_bad;
    assign mem_re     = enter_resp && op_rd && !op_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wd_q     <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            bad_q    <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q <= addr[ADDR_W+1:2];
                wd_q  <= wdata;
                rd_q  <= MemRead;
                wr_q  <= MemWrite;
                bad_q <= req_is_bad(MemRead, MemWrite, addr[1:0]);
            end
            if (mem_re) begin
                loaded_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY <= 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The array's read register holds its value between loads; gate it to zero until the first load after reset.
    always_comb begin
        ready = (state_q == RESP);
        busy  = (state_q != IDLE);
        err   = (state_q == RESP) && bad_q;
        rdata = loaded_q ? mem_rd : '0;
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dmem_array (
        .clk (clk),
        .we  (mem_we),
        .re  (mem_re),
        .idx (op_idx),
        .wd  (op_wd),
        .rd  (mem_rd)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized checks of two responders (LATENCY=2 and LATENCY=1) against a word-array reference model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] a0, wd0, a1, wd1;
    logic [31:0] rdata0, rdata1;
    logic        ready0, busy0, err0, ready1, busy1, err1;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [31:0] mem_m   [2][256];
    bit          known_m [2][256];
    logic [31:0] rd_m    [2];

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .MemRead(rd0), .MemWrite(wr0), .addr(a0), .wdata(wd0),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
    );

    data_mem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .MemRead(rd1), .MemWrite(wr1), .addr(a1), .wdata(wd1),
        .rdata(rdata1), .ready(ready1), .busy(busy1), .err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] o_ready(int s); return s ? 32'(ready1) : 32'(ready0); endfunction
    function automatic logic [31:0] o_busy(int s);  return s ? 32'(busy1)  : 32'(busy0);  endfunction
    function automatic logic [31:0] o_err(int s);   return s ? 32'(err1)   : 32'(err0);   endfunction
    function automatic logic [31:0] o_rdata(int s); return s ? rdata1 : rdata0; endfunction

    task automatic drive(input int s, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (s == 0) begin
            rd0 = r; wr0 = w; a0 = a; wd0 = d;
        end else begin
            rd1 = r; wr1 = w; a1 = a; wd1 = d;
        end
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after an edge with the DUT idle again.
    task automatic do_op(input int s, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
        int  lat;
        bit  bad;
        int  widx;
        lat  = (s == 0) ? 2 : 1;
        bad  = (a % 4 != 0) || (r && w);
        widx = int'((a / 4) % 256);
        if (!bad && w) begin
            mem_m[s][widx]   = d;
            known_m[s][widx] = 1'b1;
        end
        if (!bad && r) begin
            rd_m[s] = mem_m[s][widx];
        end
        drive(s, r, w, a, d);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k < lat) begin
                chk($sformatf("%s ready_k%0d", tag, k), o_ready(s), 32'd0);
                chk($sformatf("%s busy_k%0d", tag, k), o_busy(s), 32'd1);
                drive(s, r, w, $urandom, $urandom);
            end else begin
                chk($sformatf("%s ready", tag), o_ready(s), 32'd1);
                chk($sformatf("%s busy_resp", tag), o_busy(s), 32'd1);
                chk($sformatf("%s err", tag), o_err(s), 32'(bad));
                chk($sformatf("%s rdata", tag), o_rdata(s), rd_m[s]);
                drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        @(posedge clk); #1;
        chk($sformatf("%s idle_busy", tag), o_busy(s), 32'd0);
        chk($sformatf("%s idle_ready", tag), o_ready(s), 32'd0);
    endtask

    initial begin
        logic [31:0] ha [4];
        logic [31:0] ra;
        int          idx;
        int          kind;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        rd_m[0] = '0;
        rd_m[1] = '0;
        #1;
        chk("reset ready", 32'(ready0), 32'd0);
        chk("reset busy", 32'(busy0), 32'd0);
        chk("reset err", 32'(err0), 32'd0);
        chk("reset rdata", rdata0, 32'd0);
        chk("reset rdata1", rdata1, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Store then load
        do_op(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "t1_store");
        do_op(0, 1'b1, 1'b0, 32'h10, 32'h0, "t1_load");
        do_op(0, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, "pre_20");

        // Address wrap
        do_op(0, 1'b0, 1'b1, 32'h400, 32'h12345678, "t2_store");
        do_op(0, 1'b1, 1'b0, 32'h000, 32'h0, "t2_load");

        // Misaligned store
        do_op(0, 1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, "t3_mis");
        do_op(0, 1'b1, 1'b0, 32'h10, 32'h0, "t3_load");
        do_op(0, 1'b1, 1'b0, 32'h11, 32'h0, "t3_misld");

        // Conflicting request
        do_op(0, 1'b1, 1'b1, 32'h10, 32'h55555555, "t4_conf");
        do_op(0, 1'b1, 1'b0, 32'h10, 32'h0, "t4_load");

        // Reset in WAIT of a store
        drive(0, 1'b0, 1'b1, 32'h20, 32'hAAAA5555);
        @(posedge clk); #1;
        chk("t5 busy_wait", 32'(busy0), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5 async_ready", 32'(ready0), 32'd0);
        chk("t5 async_busy", 32'(busy0), 32'd0);
        chk("t5 async_err", 32'(err0), 32'd0);
        chk("t5 async_rdata", rdata0, 32'd0);
        rd_m[0] = '0;
        rd_m[1] = '0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("t5 no_ready_%0d", k), 32'(ready0), 32'd0);
        end
        do_op(0, 1'b1, 1'b0, 32'h20, 32'h0, "t5_load");

        // LATENCY=1 with the request held high
        ha[0] = 32'h40; ha[1] = 32'h44; ha[2] = 32'h48; ha[3] = 32'h4C;
        for (int j = 0; j < 4; j++) begin
            do_op(1, 1'b0, 1'b1, ha[j], 32'hC0DE0000 + 32'(j * 17), $sformatf("t6_pre%0d", j));
        end
        for (int j = 0; j < 4; j++) begin
            drive(1, 1'b1, 1'b0, ha[j ^ 1], 32'd0);
            rd_m[1] = mem_m[1][int'(ha[j ^ 1] / 4) % 256];
            @(posedge clk); #1;
            chk($sformatf("t6 ready_%0d", j), 32'(ready1), 32'd1);
            chk($sformatf("t6 err_%0d", j), 32'(err1), 32'd0);
            chk($sformatf("t6 rdata_%0d", j), rdata1, rd_m[1]);
            drive(1, 1'b1, 1'b0, $urandom, $urandom);
            @(posedge clk); #1;
            chk($sformatf("t6 gap_ready_%0d", j), 32'(ready1), 32'd0);
            chk($sformatf("t6 gap_busy_%0d", j), 32'(busy1), 32'd0);
        end
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        do_op(1, 1'b1, 1'b0, 32'h44, 32'h0, "t6_after");

        // Randomized traffic on the LATENCY=2 responder
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                idx = $urandom_range(0, 31);
                ra  = ($urandom & 32'hFFFFFC00) | 32'(idx * 4);
                if ($urandom_range(0, 4) == 0) ra = ra | 32'($urandom_range(1, 3));
                do_op(0, 1'b0, 1'b1, ra, $urandom, $sformatf("rnd%0d_st", i));
            end else begin
                idx = 4;
                for (int t = 0; t < 64; t++) begin
                    int c;
                    c = $urandom_range(0, 31);
                    if (known_m[0][c]) begin
                        idx = c;
                        break;
                    end
                end
                ra = ($urandom & 32'hFFFFFC00) | 32'(idx * 4);
                if ($urandom_range(0, 5) == 0) ra = ra | 32'($urandom_range(1, 3));
                do_op(0, 1'b1, (kind == 9), ra, $urandom, $sformatf("rnd%0d_ld", i));
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
